// File: rtl/cpu_pkg.sv
// Shared definitions for the CosmicProcessingUnit control path: opcode map,
// controller states, instruction classes and the small encoded decode fields.
package cpu_pkg;

  localparam logic [3:0] OP_HALT    = 4'b0000;
  localparam logic [3:0] OP_ANDI    = 4'b0001;
  localparam logic [3:0] OP_ORI     = 4'b0010;
  localparam logic [3:0] OP_BGT     = 4'b0100;
  localparam logic [3:0] OP_BLT     = 4'b0101;
  localparam logic [3:0] OP_BEQ     = 4'b0110;
  localparam logic [3:0] OP_JUMP    = 4'b0111;
  localparam logic [3:0] OP_LOAD_B  = 4'b1010;
  localparam logic [3:0] OP_STORE_B = 4'b1011;
  localparam logic [3:0] OP_LOAD_W  = 4'b1100;
  localparam logic [3:0] OP_STORE_W = 4'b1101;
  localparam logic [3:0] OP_TYPE_A  = 4'b1111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] RW_NONE    = 2'b00;
  localparam logic [1:0] RW_RD      = 2'b01;
  localparam logic [1:0] RW_RD_R15  = 2'b10;
  localparam logic [1:0] RW_RD_BYTE = 2'b11;

  localparam logic [1:0] JB_NONE   = 2'b00;
  localparam logic [1:0] JB_BRANCH = 2'b01;
  localparam logic [1:0] JB_JUMP   = 2'b10;

  localparam logic [1:0] BC_EQ = 2'b00;
  localparam logic [1:0] BC_LT = 2'b01;
  localparam logic [1:0] BC_GT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_MDWAIT = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } ctrlState;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder shared by the single-cycle and multi-cycle cores.
// Illegal opcodes (unknown low nibble or any nonzero bit above bit 3) decode to all-zero fields.
import cpu_pkg::*;

module control_decode #(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                multiDiv,
  output logic                aluBType,
  output logic                aluSrc,
  output logic                zeroExtendFlag,
  output logic                memToReg,
  output logic                memRead,
  output logic                memWrite,
  output logic [1:0]          aluControl,
  output logic [1:0]          regWrite,
  output logic [1:0]          jumpBranch,
  output logic [1:0]          branchCond,
  output logic                illegal,
  output logic                isHalt,
  output logic                isMulDiv,
  output logic                isBranch,
  output logic                isLoad,
  output logic                isStore
);

  logic upperNonZero;
  assign upperNonZero = |(opcode >> 4);

  always_comb begin
    aluBType       = 1'b0;
    aluSrc         = 1'b0;
    zeroExtendFlag = 1'b0;
    memToReg       = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    aluControl     = ALU_ADD;
    regWrite       = RW_NONE;
    jumpBranch     = JB_NONE;
    branchCond     = BC_EQ;
    illegal        = 1'b0;
    isHalt         = 1'b0;
    isMulDiv       = 1'b0;
    isBranch       = 1'b0;
    isLoad         = 1'b0;
    isStore        = 1'b0;
    if (upperNonZero) begin
      illegal = 1'b1;
    end else begin
      case (opcode[3:0])
        OP_TYPE_A: begin
          // The ALU function itself comes from the instruction's funct field in the datapath.
          isMulDiv = multiDiv;
          regWrite = multiDiv ? RW_RD_R15 : RW_RD;
        end
        OP_ANDI, OP_ORI: begin
          aluBType       = 1'b1;
          aluSrc         = 1'b1;
          zeroExtendFlag = 1'b1;
          aluControl     = (opcode[3:0] == OP_ANDI) ? ALU_AND : ALU_OR;
          regWrite       = RW_RD;
        end
        OP_LOAD_B, OP_LOAD_W: begin
          aluBType = 1'b1;
          aluSrc   = 1'b1;
          memToReg = 1'b1;
          memRead  = 1'b1;
          isLoad   = 1'b1;
          regWrite = (opcode[3:0] == OP_LOAD_B) ? RW_RD_BYTE : RW_RD;
        end
        OP_STORE_B, OP_STORE_W: begin
          aluBType = 1'b1;
          aluSrc   = 1'b1;
          memWrite = 1'b1;
          isStore  = 1'b1;
        end
        OP_BEQ, OP_BLT, OP_BGT: begin
          aluBType   = 1'b1;
          aluControl = ALU_SUB;
          jumpBranch = JB_BRANCH;
          isBranch   = 1'b1;
          branchCond = (opcode[3:0] == OP_BEQ) ? BC_EQ :
                       (opcode[3:0] == OP_BLT) ? BC_LT : BC_GT;
        end
        OP_JUMP: begin
          jumpBranch = JB_JUMP;
          isBranch   = 1'b1;
        end
        OP_HALT: isHalt = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/MDWAIT/WB with memory and
// mul/div wait states, a mul/div timeout, and absorbing HALT/TRAP states.
import cpu_pkg::*;

module multicycle_control #(
  parameter int OPCODE_W   = 4,
  parameter int MD_TIMEOUT = 32,
  parameter int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instrValid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                multiDiv,
  input  logic                memReady,
  input  logic                mdDone,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                mdStart,
  output logic                aluBType,
  output logic                aluSrc,
  output logic                zeroExtendFlag,
  output logic                memToReg,
  output logic                memRead,
  output logic                memWrite,
  output logic [1:0]          aluControl,
  output logic [1:0]          regWrite,
  output logic [1:0]          jumpBranch,
  output logic [1:0]          branchCond,
  output logic                halted,
  output logic                illegalOp,
  output logic                mdTimeout,
  output logic [2:0]          dbgState
);

  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_TIMEOUT - 1);

  ctrlState            state;
  logic [OPCODE_W-1:0] opReg;
  logic                mdReg;
  logic [CNT_W-1:0]    mdCount;
  logic                pcWriteExec;

  logic       decAluBType, decAluSrc, decZeroExt, decMemToReg, decMemRead, decMemWrite;
  logic [1:0] decAluControl, decRegWrite, decJumpBranch, decBranchCond;
  logic       decIllegal, decHalt, decMulDiv, decBranch, decLoad, decStore;

  // opReg/mdReg stay stable from FETCH until the next fetch, so the decoder output
  // remains valid for routing in every later state of the instruction.
  control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode         (opReg),
    .multiDiv       (mdReg),
    .aluBType       (decAluBType),
    .aluSrc         (decAluSrc),
    .zeroExtendFlag (decZeroExt),
    .memToReg       (decMemToReg),
    .memRead        (decMemRead),
    .memWrite       (decMemWrite),
    .aluControl     (decAluControl),
    .regWrite       (decRegWrite),
    .jumpBranch     (decJumpBranch),
    .branchCond     (decBranchCond),
    .illegal        (decIllegal),
    .isHalt         (decHalt),
    .isMulDiv       (decMulDiv),
    .isBranch       (decBranch),
    .isLoad         (decLoad),
    .isStore        (decStore)
  );

  // The fetch strobes must coincide with the instruction word being presented,
  // so they follow instrValid directly; reset masks them.
  assign irWrite  = (state == S_FETCH) && instrValid && !reset;
  assign pcWrite  = irWrite || pcWriteExec;
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_FETCH;
      opReg          <= '0;
      mdReg          <= 1'b0;
      mdCount        <= '0;
      pcWriteExec    <= 1'b0;
      mdStart        <= 1'b0;
      memRead        <= 1'b0;
      memWrite       <= 1'b0;
      regWrite       <= RW_NONE;
      aluBType       <= 1'b0;
      aluSrc         <= 1'b0;
      zeroExtendFlag <= 1'b0;
      memToReg       <= 1'b0;
      aluControl     <= ALU_ADD;
      jumpBranch     <= JB_NONE;
      branchCond     <= BC_EQ;
      halted         <= 1'b0;
      illegalOp      <= 1'b0;
      mdTimeout      <= 1'b0;
    end else begin
      mdStart     <= 1'b0;
      pcWriteExec <= 1'b0;
      regWrite    <= RW_NONE;
      case (state)
        S_FETCH: begin
          if (instrValid) begin
            opReg <= opcode;
            mdReg <= multiDiv;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          aluBType       <= decAluBType;
          aluSrc         <= decAluSrc;
          zeroExtendFlag <= decZeroExt;
          memToReg       <= decMemToReg;
          aluControl     <= decAluControl;
          jumpBranch     <= decJumpBranch;
          branchCond     <= decBranchCond;
          if (decIllegal) begin
            illegalOp <= 1'b1;
            state     <= S_TRAP;
          end else if (decHalt) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            mdStart     <= decMulDiv;
            pcWriteExec <= decBranch;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (decLoad || decStore) begin
            memRead  <= decMemRead;
            memWrite <= decMemWrite;
            state    <= S_MEM;
          end else if (decMulDiv) begin
            mdCount <= '0;
            state   <= S_MDWAIT;
          end else if (decBranch) begin
            state <= S_FETCH;
          end else begin
            regWrite <= decRegWrite;
            state    <= S_WB;
          end
        end
        S_MEM: begin
          if (memReady) begin
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            if (decLoad) begin
              regWrite <= decRegWrite;
              state    <= S_WB;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_MDWAIT: begin
          // A result arriving in the last allowed cycle is still accepted.
          if (mdDone) begin
            regWrite <= decRegWrite;
            state    <= S_WB;
          end else if (mdCount == MD_LAST) begin
            mdTimeout <= 1'b1;
            state     <= S_TRAP;
          end else begin
            mdCount <= mdCount + CNT_W'(1);
          end
        end
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
    end
  end

endmodule
